seq_ncs_comparator: RTL
=======================

// Module: seq_ncs_comparator
// PURPOSE
//  Sequential (time-iterative) N-bit unsigned magnitude comparator; complement of the spatial
//  2-bit-cell cascade comparator. One shared 2-bit compare cell is reused once per clock.
//  It scans digit pairs MSB-first and stops early at the first differing digit.
//  Slots into the same cascade scheme as the spatial comparator: eq_in/gt_in carry the result
//  of more-significant operand words; EQ/GT carry the result onward.
//  Used where area beats latency (wide operands, multi-word compares).
// PARAMETERS
//  N   8   operand width in bits; D = (N+1)/2 digits; odd N zero-extends a/b at bit N
//  CW  $clog2(D+1)  (localparam) width of digits output
// PORTS
//  clk     in   1    rising-edge clock
//  rst     in   1    asynchronous, active-high reset
//  start   in   1    request; sampled only when busy=0
//  a       in   N    operand A, captured on accepted start
//  b       in   N    operand B, captured on accepted start
//  eq_in   in   1    higher-significance words equal, captured on start
//  gt_in   in   1    higher-significance words A>B, captured on start
//  busy    out  1    high while scanning; start ignored
//  done    out  1    one-cycle pulse; EQ/GT/digits valid from this cycle
//  EQ      out  1    A==B combined with eq_in (registered, held until next accept)
//  GT      out  1    A>B combined with eq_in/gt_in (registered, held)
//  digits  out  CW   digit pairs examined for the last result
// BEHAVIOUR
//  Reset (async): state=IDLE, busy=0, done=0, EQ=0, GT=0, digits=0; internal regs cleared.
//  States: IDLE, SCAN, DONE. done=1 only in DONE; busy=1 only in SCAN.
//  Accept: rising edge with start=1 in IDLE or DONE (back-to-back allowed).
//   Latches a, b, eq_in, gt_in; digit index i=D-1; digits cleared to 0.
//   if eq_in=0 -> DONE directly: EQ=0, GT=gt_in, digits=0 (latency 1, no scan).
//   else -> SCAN.
//  SCAN, each edge: compare digit pair x={a[2i+1],a[2i]}, y={b[2i+1],b[2i]}; digits+=1.
//   x>y  -> EQ=0, GT=1, ->DONE.
//   x<y  -> EQ=0, GT=0, ->DONE.
//   x==y and i==0 -> EQ=1, GT=0, ->DONE.
//   x==y and i>0  -> i-=1, stay SCAN.
//  Combination rule (matches cascade): EQ = eq_in & (A==B); GT = gt_in | (eq_in & A>B).
//  gt_in is don't-care when eq_in=1: GT=0 on equal operands. Callers keep eq_in,gt_in exclusive.
//  DONE: single cycle. -> IDLE unless an accepted start moves to SCAN/DONE.
//  Latency: start edge -> done high after k+1 edges, k = digits examined (1..D), 1 if eq_in=0.
//  start in SCAN: ignored, not queued. a/b may change freely after the accept edge.
//  EQ/GT/digits update only on the DONE-entry edge. They are not cleared in IDLE.
//  rst mid-SCAN: aborts immediately to reset values; no done pulse.
// TESTING (N=8 unless noted; latency counted from start edge)
//  a=A5 b=A5 eq_in=1 gt_in=0 -> busy 4 cycles, done 5th cycle, EQ=1 GT=0 digits=4
//  a=C0 b=40 eq_in=1 -> top digit 3>1, done 2nd cycle, EQ=0 GT=1 digits=1
//  a=12 b=13 eq_in=1 -> differ at digit 0, done 5th cycle, EQ=0 GT=0 digits=4
//  eq_in=0 gt_in=1, any a/b -> done 1st cycle, EQ=0 GT=1 digits=0, busy never high
//  start again in SCAN (ignored, result from first op); then rst mid-SCAN -> outputs 0, no done
//  N=5: a=5'h10 b=5'h0F -> top digit {0,1}>{0,0}, done 2nd cycle, GT=1 digits=1; back-to-back starts

Source files
------------

// File: rtl/seq_ncs_comparator.sv
`default_nettype none
// ============================================================================
// Module      : seq_ncs_comparator
// Description : Time-iterative N-bit unsigned magnitude comparator. A single
//               2-bit digit compare is reused once per clock, scanning digit
//               pairs MSB-first and stopping at the first differing pair.
//               eq_in/gt_in carry the result of more-significant words so the
//               block chains like the spatial cascade comparator.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_ncs_comparator #(
    parameter int N  = 8,
    localparam int D  = (N + 1) / 2,
    localparam int CW = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  logic          eq_in,
    input  logic          gt_in,
    output logic          busy,
    output logic          done,
    output logic          EQ,
    output logic          GT,
    output logic [CW-1:0] digits
);

    // Operand width rounded up to a whole number of digits (odd N zero-extends)
    localparam int        c_W2   = 2 * D;
    localparam [CW-1:0]   c_LAST = CW'(D - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_W2-1:0]   r_a;
    logic [c_W2-1:0]   r_b;
    logic [CW-1:0]     r_cnt;

    logic [c_W2-1:0]   w_a_ext;
    logic [c_W2-1:0]   w_b_ext;
    logic [1:0]        w_x;
    logic [1:0]        w_y;
    logic              w_accept;

    assign w_a_ext  = c_W2'(a);
    assign w_b_ext  = c_W2'(b);

    // Operands are shifted left one digit per scan step, so the digit under
    // examination always sits in the top two bits of the working registers.
    assign w_x      = r_a[c_W2-1 -: 2];
    assign w_y      = r_b[c_W2-1 -: 2];
    assign w_accept = start && (r_state != S_SCAN);

    // Control FSM with registered busy/done/result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            EQ      <= 1'b0;
            GT      <= 1'b0;
            digits  <= '0;
        end else begin
            case (r_state)
                S_SCAN: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_a   <= r_a << 2;
                    r_b   <= r_b << 2;
                    if ((w_x != w_y) || (r_cnt == c_LAST)) begin
                        // First differing digit, or all digits matched
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        EQ      <= (w_x == w_y);
                        GT      <= (w_x > w_y);
                        digits  <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request (back-to-back)
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    if (w_accept) begin
                        r_a   <= w_a_ext;
                        r_b   <= w_b_ext;
                        r_cnt <= '0;
                        if (!eq_in) begin
                            // Higher words already decide the result
                            r_state <= S_DONE;
                            done    <= 1'b1;
                            EQ      <= 1'b0;
                            GT      <= gt_in;
                            digits  <= '0;
                        end else begin
                            r_state <= S_SCAN;
                            busy    <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
